// File: rtl/p_vec_pack.sv
// Serial-to-vector packer: collects IN elements of CONF.prec bits and presents them as one vector.
// Optional early close on s_last when P_VEC_PACK_FLUSH_EN is defined.

package p_vec_pack_pkg;
    typedef struct packed {
        logic [7:0]  dtype;
        logic [15:0] prec;
    } dconf_t;

    localparam dconf_t DCONF_DEFAULT = '{dtype: 8'd0, prec: 16'd8};
endpackage

`ifndef DEF_DCONF
`define DEF_DCONF p_vec_pack_pkg::DCONF_DEFAULT
`endif

module p_vec_pack
    import p_vec_pack_pkg::*;
#(
    parameter int unsigned IN   = 5,
    parameter dconf_t      CONF = `DEF_DCONF
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               s_valid,
    output logic                               s_ready,
    input  logic [CONF.prec-1:0]               s_data,
`ifdef P_VEC_PACK_FLUSH_EN
    input  logic                               s_last,
`endif
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic [IN-1:0][CONF.prec-1:0]       m_data,
    output logic [$clog2(IN+1)-1:0]            fill
);

    localparam int unsigned W  = 32'(CONF.prec);
    localparam int unsigned FW = $clog2(IN + 1);
    localparam logic [FW-1:0] IN_F   = FW'(IN);
    localparam logic [FW-1:0] LAST_F = FW'(IN - 1);

    typedef logic [IN-1:0][W-1:0] vec_t;

    vec_t            buf_q, buf_d;
    vec_t            m_data_q, m_data_d;
    vec_t            close_vec;
    logic [FW-1:0]   fill_q, fill_d;
    logic            m_valid_q, m_valid_d;
    logic            last_c;
    logic            accept;
    logic            close;
    logic            out_free;

`ifdef P_VEC_PACK_FLUSH_EN
    assign last_c = s_last;
`else
    assign last_c = 1'b0;
`endif

    assign s_ready  = (fill_q < IN_F);
    assign accept   = s_valid && s_ready;
    assign close    = accept && ((fill_q == LAST_F) || last_c);
    assign out_free = !m_valid_q || m_ready;

    // Vector formed by the element being accepted now; slots past it are zero (early close)
    always_comb begin
        close_vec = '0;
        for (int k = 0; k < int'(IN); k++) begin
            if (FW'(k) == fill_q) begin
                close_vec[k] = s_data;
            end else if (FW'(k) < fill_q) begin
                close_vec[k] = buf_q[k];
            end else begin
                close_vec[k] = '0;
            end
        end
    end

    // Next state: collect side and output register interact only at the load edge
    always_comb begin
        buf_d     = buf_q;
        fill_d    = fill_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;

        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end

        if (fill_q == IN_F) begin
            if (out_free) begin
                m_data_d  = buf_q;
                m_valid_d = 1'b1;
                fill_d    = '0;
            end
        end else if (accept) begin
            if (close) begin
                if (out_free) begin
                    m_data_d  = close_vec;
                    m_valid_d = 1'b1;
                    fill_d    = '0;
                end else begin
                    // Park the closed vector (zero-padded if early) until the output frees up
                    buf_d  = close_vec;
                    fill_d = IN_F;
                end
            end else begin
                for (int k = 0; k < int'(IN); k++) begin
                    if (FW'(k) == fill_q) begin
                        buf_d[k] = s_data;
                    end
                end
                fill_d = fill_q + FW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_q     <= '0;
            fill_q    <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            buf_q     <= buf_d;
            fill_q    <= fill_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign fill    = fill_q;

endmodule
